sram_fifo_client: RTL

Upstream requester for the SRAM arbiter's port-0 read/write channels. Turns a region of external SRAM into one large FIFO: accepts a word stream on its input, writes it to SRAM at a wrapping write pointer, reads it back in order at a wrapping read pointer, and presents the words on a first-word-fall-through output. A small on-chip prefetch FIFO with credit control absorbs SRAM read latency.

---
 rtl/sram_fifo_client.sv | 114 +++++++++++
 1 files changed

// File: rtl/sram_fifo_client.sv
// sram_fifo_client: queues a word stream through an SRAM region and returns it in order via a credit-limited prefetch FIFO
module sram_fifo_client #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 36,
  parameter int BASE_ADDR = 0,
  parameter int QUEUE_ADDR_BITS = 10,
  parameter int PREFETCH_BITS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SRAM_DATA_WIDTH-1:0] in_data,
  input  logic                       in_wr,
  output logic                       in_rdy,
  output logic [SRAM_DATA_WIDTH-1:0] out_data,
  output logic                       out_vld,
  input  logic                       out_rd,
  output logic                       wr_req,
  output logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_data,
  input  logic                       wr_ack,
  output logic                       rd_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
  input  logic                       rd_ack,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_data,
  input  logic                       rd_vld,
  output logic [QUEUE_ADDR_BITS:0]   occupancy,
  output logic                       err
);
  localparam int QW = QUEUE_ADDR_BITS;
  localparam int PW = PREFETCH_BITS;
  localparam int DEPTH = 1 << PW;
  localparam logic [SRAM_ADDR_WIDTH-1:0] BASE = SRAM_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [QW+1:0] CAP = (QW+2)'(1 << QW);
  localparam logic [QW+1:0] SAT = (QW+2)'((1 << QW) + DEPTH + 1);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW+1:0] CREDITS = (PW+2)'(DEPTH);
  typedef enum logic {W_IDLE, W_REQ} w_state_t;
  typedef enum logic {R_IDLE, R_REQ} r_state_t;
  w_state_t w_state, w_nxt;
  r_state_t r_state, r_nxt;
  logic [QW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [QW:0] committed, committed_n;
  logic [PW:0] outstanding, outstanding_n, pf_count, pf_count_n;
  logic [PW-1:0] pf_wp, pf_rp;
  logic [SRAM_DATA_WIDTH-1:0] pf_mem [DEPTH];
  logic wack, rack, accept, vld_ok, push, pop, issue_n, r_load;
  logic [QW+1:0] occ_sum;
  assign wr_req = (w_state == W_REQ);
  assign rd_req = (r_state == R_REQ);
  assign out_vld = (pf_count != '0);
  assign out_data = pf_mem[pf_rp];
  always_comb begin
    wack = wr_ack & wr_req;
    rack = rd_ack & rd_req;
    in_rdy = reset & ((w_state == W_IDLE) | wack) & (({1'b0, committed} + (QW+2)'(wr_req)) < CAP);
    accept = in_wr & in_rdy;
    vld_ok = rd_vld & (outstanding != '0);
    pop = out_rd & out_vld;
    push = vld_ok & ((pf_count < FULL) | pop);
    wr_ptr_n = wr_ptr + QW'(wack);
    rd_ptr_n = rd_ptr + QW'(rack);
    committed_n = committed + (QW+1)'(wack) - (QW+1)'(rack);
    outstanding_n = outstanding + (PW+1)'(rack) - (PW+1)'(vld_ok);
    pf_count_n = pf_count + (PW+1)'(push) - (PW+1)'(pop);
    // credits cover both in-flight returns and words already prefetched
    issue_n = (committed_n != '0) & (({1'b0, outstanding_n} + {1'b0, pf_count_n}) < CREDITS);
    w_nxt = accept ? W_REQ : wack ? W_IDLE : w_state;
    r_load = ((r_state == R_IDLE) | rack) & issue_n;
    r_nxt = ((r_state == R_IDLE) | rack) ? (issue_n ? R_REQ : R_IDLE) : r_state;
    occ_sum = {1'b0, committed} + (QW+2)'(wr_req) + (QW+2)'(outstanding) + (QW+2)'(pf_count);
    occupancy = (QW+1)'((occ_sum > SAT) ? SAT : occ_sum);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_nxt;
      r_state <= r_nxt;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      committed <= '0;
      outstanding <= '0;
      pf_count <= '0;
      pf_wp <= '0;
      pf_rp <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_addr <= '0;
      err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      committed <= committed_n;
      outstanding <= outstanding_n;
      pf_count <= pf_count_n;
      pf_wp <= pf_wp + PW'(push);
      pf_rp <= pf_rp + PW'(pop);
      if (accept) begin
        wr_addr <= BASE + SRAM_ADDR_WIDTH'(wr_ptr_n);
        wr_data <= in_data;
      end
      if (r_load) rd_addr <= BASE + SRAM_ADDR_WIDTH'(rd_ptr_n);
      err <= err | (wr_ack & ~wr_req) | (rd_ack & ~rd_req) | (rd_vld & ~vld_ok) | (vld_ok & ~push);
    end
  end
  always_ff @(posedge clk) begin
    if (push) pf_mem[pf_wp] <= rd_data;
  end
endmodule
